// File: rtl/pcs_tx_gearbox.sv
// 66b-to-DATA_WIDTH transmit gearbox.
// Takes 64b/66b blocks as {payload, sync header} and packs them LSB-first
// into a continuous DATA_WIDTH-bit stream for the PMA.
// One 64-bit word is one block. Two 32-bit words are one block, and the
// header travels only with the first word.
//
// Handshake: the upstream may present a word (i_data_valid=1) in any cycle
// where o_pause is low; that word is taken in the same cycle. o_pause is
// registered and reflects the fill level after the previous cycle, so a
// word offered while o_pause is high is dropped and flagged on
// o_overflow_err one cycle later. The output side has no backpressure:
// o_gb_valid marks each word the PMA must take.
module pcs_tx_gearbox #(
    parameter int DATA_WIDTH = 32,
    parameter int HDR_WIDTH  = 2
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_data_valid,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic [HDR_WIDTH-1:0]  i_sync_hdr,
    output logic                  o_pause,
    output logic [DATA_WIDTH-1:0] o_gb_data,
    output logic                  o_gb_valid,
    output logic                  o_overflow_err
);

    // The buffer must hold a residue of up to DATA_WIDTH-1 bits plus one
    // full block-start word. The residue is DATA_WIDTH-1 because at
    // DATA_WIDTH or more bits the gearbox pauses.
    localparam int BUF_W = 2 * DATA_WIDTH + HDR_WIDTH;
    localparam int CNT_W = $clog2(BUF_W + 1);

    localparam logic [CNT_W-1:0] WORD_BITS  = CNT_W'(DATA_WIDTH);
    localparam logic [CNT_W-1:0] START_BITS = CNT_W'(DATA_WIDTH + HDR_WIDTH);

    // With a 32-bit datapath a block spans two words; with 64 bits it is one.
    localparam bit TWO_WORD_BLOCK = (DATA_WIDTH == 32);

    // Bit buffer: bits [fill_q-1:0] are valid, everything above is zero.
    logic [BUF_W-1:0] bit_buf_q;
    logic [CNT_W-1:0] fill_q;
    // 0: next accepted word starts a block; 1: next word is the block's second half.
    logic             word_idx_q;

    logic             accept;
    logic             block_start;
    logic [BUF_W-1:0] add_vec;
    logic [CNT_W-1:0] add_len;
    logic [BUF_W-1:0] merged;
    logic [CNT_W-1:0] total;
    logic             emit;
    logic [BUF_W-1:0] bit_buf_next;
    logic [CNT_W-1:0] fill_next;
    logic             word_idx_next;

    // Append the accepted word at the fill point, then decide whether a word leaves.
    always_comb begin
        accept        = i_data_valid & ~o_pause;
        block_start   = ~TWO_WORD_BLOCK | ~word_idx_q;
        add_vec       = '0;
        add_len       = '0;
        bit_buf_next  = '0;
        fill_next     = '0;
        word_idx_next = 1'b0;

        if (accept) begin
            if (block_start) begin
                // Header occupies the low bits so it goes on the wire first.
                add_vec = BUF_W'({i_data, i_sync_hdr});
                add_len = START_BITS;
            end else begin
                add_vec = BUF_W'(i_data);
                add_len = WORD_BITS;
            end
        end

        merged = bit_buf_q | (add_vec << fill_q);
        total  = fill_q + add_len;
        emit   = (total >= WORD_BITS);

        if (emit) begin
            bit_buf_next = merged >> DATA_WIDTH;
            fill_next    = total - WORD_BITS;
        end else begin
            bit_buf_next = merged;
            fill_next    = total;
        end

        // The block phase only advances on words actually taken, so a pause
        // or a dropped word never desynchronises header placement.
        if (TWO_WORD_BLOCK) begin
            word_idx_next = word_idx_q ^ accept;
        end
    end

    // Buffer, fill level, block phase and registered outputs.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            bit_buf_q      <= '0;
            fill_q         <= '0;
            word_idx_q     <= 1'b0;
            o_pause        <= 1'b0;
            o_gb_data      <= '0;
            o_gb_valid     <= 1'b0;
            o_overflow_err <= 1'b0;
        end else begin
            bit_buf_q      <= bit_buf_next;
            fill_q         <= fill_next;
            word_idx_q     <= word_idx_next;
            // A full output word still buffered means the next cycle is spent
            // draining it, so the upstream has to hold off for that cycle.
            o_pause        <= (fill_next >= WORD_BITS);
            o_gb_valid     <= emit;
            if (emit) begin
                o_gb_data <= merged[DATA_WIDTH-1:0];
            end
            o_overflow_err <= i_data_valid & o_pause;
        end
    end

endmodule
